// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter.
//   state_t : arbiter FSM states (IDLE = nothing pending, PEND = CPU access waiting)
//   WAIT_W  : width of the CPU starvation counter (holds MAX_WAIT up to 15)
//   bank_w  : bank-select width, never less than one bit
package vram_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam int WAIT_W = 4;

    function automatic int bank_w(input int banks);
        return (banks <= 2) ? 1 : $clog2(banks);
    endfunction

endpackage

// File: rtl/vram_arb_if.sv
// Bundle of the arbiter's video and CPU side signals.
//   master : the requesting side (drives requests, observes responses)
//   slave  : the arbiter side (observes requests, drives responses)
interface vram_arb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13,
    parameter int BANK_W = 1
) ();

    logic              vid_req;
    logic [BANK_W-1:0] vid_bank;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_q;
    logic              vid_miss;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_bank_we;
    logic [BANK_W-1:0] cpu_bank_d;
    logic [BANK_W-1:0] cpu_bank;

    modport master (
        output vid_req, vid_bank, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               cpu_bank_we, cpu_bank_d,
        input  vid_valid, vid_q, vid_miss, cpu_busy, cpu_ack, cpu_rdata, cpu_bank
    );

    modport slave (
        input  vid_req, vid_bank, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               cpu_bank_we, cpu_bank_d,
        output vid_valid, vid_q, vid_miss, cpu_busy, cpu_ack, cpu_rdata, cpu_bank
    );

endinterface

// File: rtl/vram_array.sv
// Single-port synchronous RAM with a registered read port (1-cycle latency).
//   i_clk   : clock
//   i_en    : access enable, at most one access per cycle
//   i_we    : 1 = write i_wdata, 0 = read into o_rdata
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : read data, updated only by read accesses
module vram_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16384,
    parameter int AW     = 14
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/vram_arb.sv
// VRAM arbiter: shares one single-port banked RAM between a video reader
// (priority) and a CPU port that is forced through after MAX_WAIT cycles.
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   vid_req/bank/addr        : video read request for this cycle
//   vid_valid/vid_q          : video read result, one cycle after the grant
//   vid_miss                 : video request of the previous cycle was dropped
//   cpu_req/we/addr/wdata    : CPU access request (ignored while cpu_busy)
//   cpu_busy                 : a captured CPU access is waiting for a slot
//   cpu_ack/cpu_rdata        : completion pulse; read data held until next read ack
//   cpu_bank_we/d, cpu_bank  : CPU bank register
module vram_arb
    import vram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 13,
    parameter int BANKS    = 2,
    parameter int MAX_WAIT = 4,
    localparam int BANK_W  = bank_w(BANKS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [BANK_W-1:0] vid_bank,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_q,
    output logic              vid_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_bank_we,
    input  logic [BANK_W-1:0] cpu_bank_d,
    output logic [BANK_W-1:0] cpu_bank
);

    localparam int AW    = BANK_W + ADDR_W;
    localparam int DEPTH = BANKS * (2 ** ADDR_W);

    function automatic logic bank_ok(input logic [BANK_W-1:0] b);
        return {1'b0, b} < (BANK_W + 1)'(BANKS);
    endfunction

    state_t              r_state, w_state_nxt;
    logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BANK_W-1:0]   r_bank;
    logic [BANK_W-1:0]   r_cpu_bank;
    logic                r_vid_valid, r_vid_miss, r_cpu_ack, r_ack_rd, r_rd_oob;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_cpu_gnt, w_vid_gnt, w_capture;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [BANK_W-1:0]   w_sel_bank;
    logic                w_ram_en, w_ram_we, w_rd_oob;
    logic [AW-1:0]       w_ram_addr;
    logic [DATA_W-1:0]   w_ram_q, w_ram_q_m;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_cpu_gnt   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (!vid_req) begin
                        w_cpu_gnt = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_PEND;
                        w_wait_nxt  = WAIT_W'(1);
                    end
                end
            end
            ST_PEND: begin
                // Any video gap, or the starvation limit, lets the CPU through.
                if (!vid_req || r_wait == WAIT_W'(MAX_WAIT)) begin
                    w_cpu_gnt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wait_nxt  = '0;
            end
        endcase
        w_vid_gnt = vid_req && !w_cpu_gnt;
    end

    // An immediate grant uses the live request; a pending one uses the capture.
    // The CPU bank register is read before this edge's cpu_bank_we takes effect.
    assign w_sel_we    = (r_state == ST_PEND) ? r_we    : cpu_we;
    assign w_sel_addr  = (r_state == ST_PEND) ? r_addr  : cpu_addr;
    assign w_sel_wdata = (r_state == ST_PEND) ? r_wdata : cpu_wdata;
    assign w_sel_bank  = (r_state == ST_PEND) ? r_bank  : r_cpu_bank;

    // Out-of-range banks never touch the RAM; reset blocks a grant in flight.
    assign w_rd_oob   = w_cpu_gnt ? !bank_ok(w_sel_bank) : !bank_ok(vid_bank);
    assign w_ram_en   = !reset && (w_cpu_gnt || w_vid_gnt) && !w_rd_oob;
    assign w_ram_we   = w_cpu_gnt && w_sel_we;
    assign w_ram_addr = w_cpu_gnt ? {w_sel_bank, w_sel_addr} : {vid_bank, vid_addr};

    vram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .i_clk   (clock),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_cpu_bank  <= '0;
            r_vid_valid <= 1'b0;
            r_vid_miss  <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ack_rd    <= 1'b0;
            r_rd_oob    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait      <= w_wait_nxt;
            if (cpu_bank_we) begin
                r_cpu_bank <= cpu_bank_d;
            end
            r_vid_valid <= w_vid_gnt;
            r_vid_miss  <= vid_req && w_cpu_gnt;
            r_cpu_ack   <= w_cpu_gnt;
            r_ack_rd    <= w_cpu_gnt && !w_sel_we;
            r_rd_oob    <= w_rd_oob;
            if (r_ack_rd) begin
                r_rdata <= w_ram_q_m;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_bank  <= r_cpu_bank;
        end
    end

    // The RAM output register is live during the cycle after a grant; read
    // data is taken straight from it then and held afterwards.
    assign w_ram_q_m = r_rd_oob ? '0 : w_ram_q;
    assign vid_valid = r_vid_valid;
    assign vid_q     = r_vid_valid ? w_ram_q_m : '0;
    assign vid_miss  = r_vid_miss;
    assign cpu_busy  = (r_state == ST_PEND);
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_ack_rd ? w_ram_q_m : r_rdata;
    assign cpu_bank  = r_cpu_bank;

endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb: each vector is applied for one clock and the
// registered outputs are compared just after that edge.
module tb_vram_arb;

    localparam int DW = 8;
    localparam int AW = 13;
    localparam int NB = 3;
    localparam int MW = 4;
    localparam int BW = 2;

    typedef struct {
        string           name;
        logic            vr;
        logic [BW-1:0]   vb;
        logic [AW-1:0]   va;
        logic            cr;
        logic            cw;
        logic [AW-1:0]   ca;
        logic [DW-1:0]   cd;
        logic            bwe;
        logic [BW-1:0]   bd;
        logic            e_vv;
        logic [DW-1:0]   e_vq;
        logic            e_vm;
        logic            e_busy;
        logic            e_ack;
        logic [DW-1:0]   e_rd;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t tbl [16];

    vram_arb_if #(.DATA_W(DW), .ADDR_W(AW), .BANK_W(BW)) bus ();

    vram_arb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .BANKS    (NB),
        .MAX_WAIT (MW)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .vid_req     (bus.vid_req),
        .vid_bank    (bus.vid_bank),
        .vid_addr    (bus.vid_addr),
        .vid_valid   (bus.vid_valid),
        .vid_q       (bus.vid_q),
        .vid_miss    (bus.vid_miss),
        .cpu_req     (bus.cpu_req),
        .cpu_we      (bus.cpu_we),
        .cpu_addr    (bus.cpu_addr),
        .cpu_wdata   (bus.cpu_wdata),
        .cpu_busy    (bus.cpu_busy),
        .cpu_ack     (bus.cpu_ack),
        .cpu_rdata   (bus.cpu_rdata),
        .cpu_bank_we (bus.cpu_bank_we),
        .cpu_bank_d  (bus.cpu_bank_d),
        .cpu_bank    (bus.cpu_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string n,
                                input logic vr, input logic [BW-1:0] vb, input logic [AW-1:0] va,
                                input logic cr, input logic cw, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd, input logic bwe, input logic [BW-1:0] bd,
                                input logic vv, input logic [DW-1:0] vq, input logic vm,
                                input logic bz, input logic ak, input logic [DW-1:0] rd);
        vec_t v;
        v.name = n;  v.vr = vr;  v.vb = vb;  v.va = va;
        v.cr = cr;   v.cw = cw;  v.ca = ca;  v.cd = cd;
        v.bwe = bwe; v.bd = bd;
        v.e_vv = vv; v.e_vq = vq; v.e_vm = vm; v.e_busy = bz; v.e_ack = ak; v.e_rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.vid_req     = v.vr;
        bus.vid_bank    = v.vb;
        bus.vid_addr    = v.va;
        bus.cpu_req     = v.cr;
        bus.cpu_we      = v.cw;
        bus.cpu_addr    = v.ca;
        bus.cpu_wdata   = v.cd;
        bus.cpu_bank_we = v.bwe;
        bus.cpu_bank_d  = v.bd;
        @(posedge clk);
        #1;
        chk({v.name, " vid_valid"}, 32'(bus.vid_valid), 32'(v.e_vv));
        chk({v.name, " vid_q"},     32'(bus.vid_q),     32'(v.e_vq));
        chk({v.name, " vid_miss"},  32'(bus.vid_miss),  32'(v.e_vm));
        chk({v.name, " cpu_busy"},  32'(bus.cpu_busy),  32'(v.e_busy));
        chk({v.name, " cpu_ack"},   32'(bus.cpu_ack),   32'(v.e_ack));
        chk({v.name, " cpu_rdata"}, 32'(bus.cpu_rdata), 32'(v.e_rd));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.vid_req = 1'b0;  bus.vid_bank = '0;  bus.vid_addr = '0;
        bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.cpu_bank_we = 1'b0;  bus.cpu_bank_d = '0;

        //             name      vr   vb     va        cr   cw   ca        cd     bwe  bd     vv   vq     vm   bz   ak   rd
        tbl[0]  = mk("bank1",  1'b0, 2'd0, 13'h000, 1'b0, 1'b0, 13'h000, 8'h00, 1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[1]  = mk("wr_a5",  1'b0, 2'd0, 13'h000, 1'b1, 1'b1, 13'h100, 8'hA5, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        tbl[2]  = mk("vid_rd", 1'b1, 2'd1, 13'h100, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[3]  = mk("cpu_rd", 1'b0, 2'd0, 13'h000, 1'b1, 1'b0, 13'h100, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5);
        tbl[4]  = mk("wr_5a",  1'b0, 2'd0, 13'h000, 1'b1, 1'b1, 13'h200, 8'h5A, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5);
        tbl[5]  = mk("cont0",  1'b1, 2'd1, 13'h100, 1'b1, 1'b0, 13'h200, 8'h00, 1'b0, 2'd0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[6]  = mk("cont1",  1'b1, 2'd1, 13'h100, 1'b1, 1'b1, 13'h100, 8'hFF, 1'b0, 2'd0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[7]  = mk("cont2",  1'b1, 2'd1, 13'h100, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[8]  = mk("cont3",  1'b1, 2'd1, 13'h100, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5);
        tbl[9]  = mk("cont4",  1'b1, 2'd1, 13'h100, 1'b1, 1'b1, 13'h100, 8'hEE, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A);
        tbl[10] = mk("cont5",  1'b1, 2'd1, 13'h100, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h5A);
        tbl[11] = mk("gap0",   1'b1, 2'd1, 13'h200, 1'b1, 1'b0, 13'h100, 8'h00, 1'b0, 2'd0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A);
        tbl[12] = mk("gap1",   1'b1, 2'd1, 13'h200, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A);
        tbl[13] = mk("gap2",   1'b0, 2'd0, 13'h000, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5);
        tbl[14] = mk("gap3",   1'b0, 2'd0, 13'h000, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5);
        tbl[15] = mk("vid_oob",1'b1, 2'd3, 13'h100, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst vid_valid", 32'(bus.vid_valid), 32'd0);
        chk("rst vid_q",     32'(bus.vid_q),     32'd0);
        chk("rst vid_miss",  32'(bus.vid_miss),  32'd0);
        chk("rst cpu_busy",  32'(bus.cpu_busy),  32'd0);
        chk("rst cpu_ack",   32'(bus.cpu_ack),   32'd0);
        chk("rst cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst cpu_bank",  32'(bus.cpu_bank),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(tbl[i]);
        end

        // Bank register update races a request: the old bank is used.
        run_vec(mk("bk0",    1'b0, 2'd0, 13'h000, 1'b0, 1'b0, 13'h000, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5));
        chk("bk0 cpu_bank", 32'(bus.cpu_bank), 32'd0);
        run_vec(mk("bk_wr0", 1'b0, 2'd0, 13'h000, 1'b1, 1'b1, 13'h300, 8'h77, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5));
        chk("bk_wr0 cpu_bank", 32'(bus.cpu_bank), 32'd3);
        run_vec(mk("bk_wr3", 1'b0, 2'd0, 13'h000, 1'b1, 1'b1, 13'h300, 8'h99, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5));
        run_vec(mk("bk_rd3", 1'b0, 2'd0, 13'h000, 1'b1, 1'b0, 13'h300, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00));
        run_vec(mk("bk_sel0",1'b0, 2'd0, 13'h000, 1'b0, 1'b0, 13'h000, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
        run_vec(mk("bk_rd0", 1'b0, 2'd0, 13'h000, 1'b1, 1'b0, 13'h300, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77));

        // Reset while a CPU write is pending at wait=2 drops it.
        run_vec(mk("rp0",    1'b1, 2'd0, 13'h300, 1'b1, 1'b1, 13'h300, 8'h11, 1'b0, 2'd0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'h77));
        run_vec(mk("rp1",    1'b1, 2'd0, 13'h300, 1'b0, 1'b0, 13'h000, 8'h00, 1'b1, 2'd2, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'h77));
        chk("rp1 cpu_bank", 32'(bus.cpu_bank), 32'd2);
        rst = 1'b1;
        run_vec(mk("rp_rst", 1'b0, 2'd0, 13'h000, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
        chk("rp_rst cpu_bank", 32'(bus.cpu_bank), 32'd0);
        rst = 1'b0;
        run_vec(mk("rp_after",1'b0, 2'd0, 13'h000, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
        run_vec(mk("rp_rd",  1'b0, 2'd0, 13'h000, 1'b1, 1'b0, 13'h300, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
